// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the mod_counter block.
// FSM state encoding and default parameter values live here so the top
// and any testbench agree on them.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/counter_prescaler.sv
// Step-rate prescaler for mod_counter.
// tick is high on one of every div+1 enabled cycles. The internal count
// only advances while en is high, so gaps in en stretch the interval.
// clr restarts the interval from zero and takes priority over en.
module counter_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    // >= rather than == so that lowering div below the current count
    // produces a tick immediately instead of running all the way round.
    assign tick = (cnt >= div);

    // Interval counter: restart on clr or after each tick, advance when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with run/stop/oneshot sequencing.
//
//   state | meaning
//   ------+------------------------------------------------------
//   IDLE  | halted, waiting for start
//   RUN   | stepping on every enabled tick
//   DONE  | oneshot reached its terminal value, waiting for start/stop
//
// Optional build macro MOD_COUNTER_PRESCALE_EN adds the presc_div port and a
// counter_prescaler that divides the step rate by presc_div+1. Without it
// every enabled RUN cycle is a step.
//
// tc is a one-cycle pulse after a wrapping/terminal step. It is not held
// across en=0 cycles; holding it would stretch the pulse past one cycle.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MODULUS    = 2**WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  up,
    input  logic                  oneshot,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  ovf_clr,
`ifdef MOD_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (PRESCALE_W < 1) begin : g_bad_prescale_w
        $error("mod_counter: PRESCALE_W must be at least 1");
    end

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    state_t           state;
    logic             tick;
    logic             step;
    logic             wrap;
    logic             start_ok;
    logic [WIDTH-1:0] load_sat;

    // A start that is not cancelled by stop or masked by load leaves IDLE/DONE.
    assign start_ok = start && !stop && !load && (state != RUN);

    // Load has priority over a step; stop in RUN also suppresses the step.
    assign step = (state == RUN) && en && tick && !stop && !load;
    assign wrap = up ? (count == TOP_VAL) : (count == '0);

    assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? TOP_VAL : load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
    logic presc_clr;

    // Each run starts with a full prescale interval, as does each load.
    assign presc_clr = load || start_ok;

    counter_prescaler #(
        .WIDTH (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   ((state == RUN) && en),
        .div  (presc_div),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Count value, terminal pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc <= 1'b0;

            // Setting wins over a simultaneous clear.
            if (step && wrap && !oneshot) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            if (load) begin
                count <= load_sat;
            end else if (step) begin
                if (wrap) begin
                    tc <= 1'b1;
                    // Oneshot parks on the terminal value instead of wrapping.
                    if (!oneshot) begin
                        count <= up ? '0 : TOP_VAL;
                    end
                end else if (up) begin
                    count <= count + WIDTH'(1);
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

    // Sequencing FSM with busy/done registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (!load) begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (step && wrap && oneshot) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (start_ok) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
